cordic_hyp_arbiter: RTL and testbench

Two-requester scheduler wrapped around the 16-stage pipelined hyperbolic vectoring CORDIC core (atanh / sqrt datapath). It accepts operand triples from two independent requesters over valid/ready handshakes and round-robin arbitrates one issue per cycle into the core. The core itself carries no valid or tag, so this block tracks every in-flight operation in a tag delay line and steers each result into a per-requester result FIFO. Issue is credit-gated so the FIFOs never overflow.

---
 rtl/cordic_hyp_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cordic_hyp_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_hyp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_hyp_arbiter
// Function : Two-requester round-robin front end with credit-gated issue,
//            tag-tracked result steering and per-requester result FIFOs
//            around a 16-stage pipelined hyperbolic vectoring CORDIC core.
// Revision : 1.0  initial release
// ============================================================================
module cordic_hyp_arbiter #(
    parameter int CORE_LAT   = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_z,
    output logic [1:0]  res_valid,
    input  logic [1:0]  res_ready,
    output logic [31:0] res_x,
    output logic [31:0] res_y,
    output logic [31:0] res_z,
    output logic        busy
);

    localparam int c_STAGES = 16;
    localparam int c_CW     = $clog2(FIFO_DEPTH + 1);
    localparam int c_AW     = $clog2(FIFO_DEPTH);

    // Iteration schedule 1,2,3,4,4,5..13,13,14 (indices 4 and 13 repeat for convergence)
    function automatic int f_shift(input int s);
        if (s <= 3)       return s + 1;
        else if (s <= 13) return s;
        else              return s - 1;
    endfunction

    // atanh(2^-i) in Q1.14
    function automatic logic signed [15:0] f_atanh(input int sh);
        case (sh)
            1:       return 16'sd9000;
            2:       return 16'sd4185;
            3:       return 16'sd2059;
            4:       return 16'sd1025;
            5:       return 16'sd512;
            6:       return 16'sd256;
            7:       return 16'sd128;
            8:       return 16'sd64;
            9:       return 16'sd32;
            10:      return 16'sd16;
            11:      return 16'sd8;
            12:      return 16'sd4;
            13:      return 16'sd2;
            14:      return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    logic [1:0]  w_elig;
    logic [1:0]  w_grant;
    logic [1:0]  w_accept;
    logic [1:0]  w_has_credit;
    logic        r_last;
    logic [15:0] w_in_x;
    logic [15:0] w_in_y;
    logic [15:0] w_in_z;

    always_comb begin
        w_elig  = req_valid & w_has_credit;
        w_grant = 2'b00;
        if (w_elig == 2'b11) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end else begin
            w_grant = w_elig;
        end
        if (rst) begin
            w_grant = 2'b00;
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = req_valid & w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|w_grant) begin
            r_last <= w_grant[1];
        end
    end

    assign w_in_x = w_grant[1] ? req_x[31:16] : req_x[15:0];
    assign w_in_y = w_grant[1] ? req_y[31:16] : req_y[15:0];
    assign w_in_z = w_grant[1] ? req_z[31:16] : req_z[15:0];

    // Core datapath: input register followed by 16 rotation stages, no reset
    logic signed [15:0] r_cx [c_STAGES+1];
    logic signed [15:0] r_cy [c_STAGES+1];
    logic signed [15:0] r_cz [c_STAGES+1];

    always_ff @(posedge clk) begin
        r_cx[0] <= w_in_x;
        r_cy[0] <= w_in_y;
        r_cz[0] <= w_in_z;
        for (int s = 0; s < c_STAGES; s++) begin
            if (r_cy[s][15]) begin
                r_cx[s+1] <= r_cx[s] + (r_cy[s] >>> f_shift(s));
                r_cy[s+1] <= r_cy[s] + (r_cx[s] >>> f_shift(s));
                r_cz[s+1] <= r_cz[s] - f_atanh(f_shift(s));
            end else begin
                r_cx[s+1] <= r_cx[s] - (r_cy[s] >>> f_shift(s));
                r_cy[s+1] <= r_cy[s] - (r_cx[s] >>> f_shift(s));
                r_cz[s+1] <= r_cz[s] + f_atanh(f_shift(s));
            end
        end
    end

    // Tag line: the last entry lines up with the core output registers
    logic [CORE_LAT-1:0] r_tv;
    logic [CORE_LAT-1:0] r_tid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tv  <= '0;
            r_tid <= '0;
        end else begin
            r_tv  <= {r_tv[CORE_LAT-2:0], |w_accept};
            r_tid <= {r_tid[CORE_LAT-2:0], w_grant[1]};
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_req
        logic [15:0]     r_mx [FIFO_DEPTH];
        logic [15:0]     r_my [FIFO_DEPTH];
        logic [15:0]     r_mz [FIFO_DEPTH];
        logic [c_AW-1:0] r_wp;
        logic [c_AW-1:0] r_rp;
        logic [c_CW-1:0] r_cnt;
        logic [c_CW-1:0] r_credit;
        logic            w_wr;
        logic            w_rd;

        assign w_wr = r_tv[CORE_LAT-1] && (r_tid[CORE_LAT-1] == 1'(i));
        assign w_rd = res_ready[i] && (r_cnt != '0);

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mx[r_wp] <= r_cx[c_STAGES];
                r_my[r_wp] <= r_cy[c_STAGES];
                r_mz[r_wp] <= r_cz[c_STAGES];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp     <= '0;
                r_rp     <= '0;
                r_cnt    <= '0;
                r_credit <= c_CW'(FIFO_DEPTH);
            end else begin
                if (w_wr) r_wp <= r_wp + 1'b1;
                if (w_rd) r_rp <= r_rp + 1'b1;
                case ({w_wr, w_rd})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
                case ({w_accept[i], w_rd})
                    2'b10:   r_credit <= r_credit - 1'b1;
                    2'b01:   r_credit <= r_credit + 1'b1;
                    default: r_credit <= r_credit;
                endcase
            end
        end

        // Credits must make a write into a full FIFO impossible
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert (!(w_wr && !w_rd && (r_cnt == c_CW'(FIFO_DEPTH))));
            end
        end

        assign w_has_credit[i]  = (r_credit != '0);
        assign res_valid[i]     = (r_cnt != '0);
        assign res_x[16*i +: 16] = r_mx[r_rp];
        assign res_y[16*i +: 16] = r_my[r_rp];
        assign res_z[16*i +: 16] = r_mz[r_rp];
    end

    assign busy = (|r_tv) || (|res_valid);

endmodule
`default_nettype wire

// File: tb/tb_cordic_hyp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_hyp_arbiter
// Function : Scoreboard bench for cordic_hyp_arbiter with a reference CORDIC.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_hyp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_x = '0, req_y = '0, req_z = '0;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready = 2'b00;
    logic [31:0] res_x, res_y, res_z;
    logic        busy;

    always #5 clk = ~clk;

    cordic_hyp_arbiter #(.CORE_LAT(17), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [47:0] sbq0[$];
    logic [47:0] sbq1[$];
    int nacc[2] = '{0, 0};
    int npop[2] = '{0, 0};
    int opn = 0;

    int SHT[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
    logic signed [15:0] ANG[15] = '{16'sd0, 16'sd9000, 16'sd4185, 16'sd2059, 16'sd1025,
                                    16'sd512, 16'sd256, 16'sd128, 16'sd64, 16'sd32,
                                    16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1};

    task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] model(input logic [15:0] xi, input logic [15:0] yi,
                                          input logic [15:0] zi);
        logic signed [15:0] x, y, z, tx;
        x = xi; y = yi; z = zi;
        for (int k = 0; k < 16; k++) begin
            tx = x;
            if (y < 0) begin
                x = x + (y >>> SHT[k]);
                y = y + (tx >>> SHT[k]);
                z = z - ANG[SHT[k]];
            end else begin
                x = x - (y >>> SHT[k]);
                y = y - (tx >>> SHT[k]);
                z = z + ANG[SHT[k]];
            end
        end
        return {x, y, z};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        opn++;
        req_x = {16'h2c00 + 16'(opn * 'h13), 16'h2800 + 16'(opn * 'h11)};
        req_y = {16'h0100 - 16'(opn * 'h2b), 16'(opn * 'h37) - 16'h0200};
        req_z = {16'(opn * 'h05), 16'(opn * 'h09)};
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 48'(busy), 48'd0);
    endtask

    // Scoreboard: push on accept, pop/compare on result pop
    initial begin
        logic [47:0] got, e;
        logic        avail;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e = model(req_x[16*i +: 16], req_y[16*i +: 16], req_z[16*i +: 16]);
                        if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
                        nacc[i]++;
                    end
                    if (res_valid[i] && res_ready[i]) begin
                        npop[i]++;
                        got   = {res_x[16*i +: 16], res_y[16*i +: 16], res_z[16*i +: 16]};
                        avail = (i == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
                        check_eq($sformatf("sb_avail%0d", i), 48'(avail), 48'd1);
                        if (avail) begin
                            e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                            check_eq($sformatf("res_data%0d", i), got, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int a0, a1, cnt;
        // Reset state, with requests presented during reset
        req_valid = 2'b11;
        tick(); tick();
        check_eq("rst_req_ready", 48'(req_ready), 48'd0);
        check_eq("rst_res_valid", 48'(res_valid), 48'd0);
        check_eq("rst_busy", 48'(busy), 48'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Single op: latency and data
        req_x = 32'h0000_3000; req_y = 32'h0000_1000; req_z = 32'h0;
        req_valid = 2'b01;
        #1 check_eq("single_ready", 48'(req_ready), 48'd1);
        tick();
        req_valid = 2'b00;
        check_eq("single_busy", 48'(busy), 48'd1);
        for (int k = 1; k < 17; k++) tick();
        check_eq("lat_minus1", 48'(res_valid), 48'd0);
        tick();
        check_eq("lat_exact", 48'(res_valid), 48'd1);
        res_ready = 2'b01;
        tick();
        res_ready = 2'b00;
        check_eq("single_busy_after", 48'(busy), 48'd0);
        check_eq("single_pops", 48'(npop[0]), 48'd1);

        // Contention: alternating grants, starting with requester 1
        res_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            drive_ops();
            #1 check_eq($sformatf("rr_grant%0d", k), 48'(req_ready),
                        48'((k % 2 == 0) ? 2 : 1));
            tick();
        end
        req_valid = 2'b00;
        wait_idle("rr_idle");
        check_eq("rr_pops0", 48'(npop[0]), 48'd5);
        check_eq("rr_pops1", 48'(npop[1]), 48'd4);

        // Credit stall on requester 0 while requester 1 keeps flowing
        a0 = nacc[0]; a1 = nacc[1];
        res_ready = 2'b10;
        req_valid = 2'b11;
        for (int k = 0; k < 30; k++) begin drive_ops(); tick(); end
        check_eq("stall_acc0", 48'(nacc[0] - a0), 48'd4);
        check_eq("stall_ready0", 48'(req_ready[0]), 48'd0);
        check_eq("stall_acc1_flow", 48'((nacc[1] - a1) > 4), 48'd1);
        check_eq("stall_full_valid", 48'(res_valid[0]), 48'd1);
        a0 = nacc[0];
        res_ready = 2'b11;
        tick();
        res_ready = 2'b10;
        for (int k = 0; k < 15; k++) begin drive_ops(); tick(); end
        check_eq("stall_one_more", 48'(nacc[0] - a0), 48'd1);
        req_valid = 2'b00;
        res_ready = 2'b11;
        wait_idle("stall_idle");
        res_ready = 2'b00;

        // Simultaneous write+pop (occupancy) and accept+pop (credit)
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin drive_ops(); tick(); end
        req_valid = 2'b00;
        for (int k = 0; k < 16; k++) tick();
        a0 = nacc[0];
        drive_ops();
        req_valid = 2'b01;
        res_ready = 2'b01;
        tick();
        res_ready = 2'b00;
        check_eq("simul_accept", 48'(nacc[0] - a0), 48'd1);
        for (int k = 0; k < 10; k++) begin drive_ops(); tick(); end
        check_eq("simul_credit", 48'(nacc[0] - a0), 48'd2);
        req_valid = 2'b00;
        for (int k = 0; k < 25; k++) tick();
        res_ready = 2'b01;
        cnt = 0;
        while (res_valid[0] && cnt < 10) begin tick(); cnt++; end
        check_eq("simul_occupancy", 48'(cnt), 48'd4);
        res_ready = 2'b00;
        wait_idle("simul_idle");

        // Reset mid-flight
        a0 = nacc[0] + nacc[1];
        req_valid = 2'b11;
        cnt = 0;
        while ((nacc[0] + nacc[1] - a0) < 5 && cnt < 20) begin drive_ops(); tick(); cnt++; end
        req_valid = 2'b00;
        check_eq("mid_inflight", 48'(nacc[0] + nacc[1] - a0), 48'd5);
        tick(); tick(); tick();
        rst = 1'b1;
        sbq0.delete();
        sbq1.delete();
        tick();
        rst = 1'b0;
        drive_ops();
        req_valid = 2'b10;
        #1;
        check_eq("mid_res_valid", 48'(res_valid), 48'd0);
        check_eq("mid_busy", 48'(busy), 48'd0);
        check_eq("mid_first_accept", 48'(req_ready), 48'd2);
        tick();
        req_valid = 2'b00;
        cnt = 0;
        for (int k = 1; k < 17; k++) begin
            tick();
            if (res_valid != 2'b00) cnt++;
        end
        check_eq("mid_no_stale", 48'(cnt), 48'd0);
        tick();
        check_eq("mid_new_result", 48'(res_valid), 48'd2);
        res_ready = 2'b10;
        tick();
        res_ready = 2'b00;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (res_valid != 2'b00) cnt++;
        end
        check_eq("mid_no_stale_tail", 48'(cnt), 48'd0);
        wait_idle("final_idle");
        check_eq("sb_drained", 48'(sbq0.size() + sbq1.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
